matmul_result_checker: RTL and testbench
========================================

// Module: matmul_result_checker
// PURPOSE
//   In-system golden checker for the matrix-multiply workload. Once the CPU raises done, it walks
//   data memory through a spare read port. For each result element it recomputes R = A x B with
//   its own multiply-accumulate and compares it with the CPU-written word. It reports pass/fail,
//   the mismatch count and the first bad index, so checking works on silicon, not only in sim.
// PARAMETERS
//   M       100          rows of matrix1 / result
//   N       50           cols of matrix1 = rows of matrix2 (N >= 1)
//   N2      2            cols of matrix2 / result
//   WIDTH   32           data word width, signed two's complement
//   ADDR_W  16           word-address width of the memory read port
//   BASE_A  0            word address of matrix1, row-major
//   BASE_B  M*N          word address of matrix2, row-major
//   BASE_R  M*N+N*N2     word address of result, row-major
// PORTS
//   CLOCK_50      in   1        system clock, rising edge
//   rst_n         in   1        asynchronous active-low reset
//   start         in   1        1-cycle pulse (CPU done rise); ignored while busy
//   mem_rd        out  1        read strobe
//   mem_addr      out  ADDR_W   word read address
//   mem_rdata     in   WIDTH    read data, valid exactly 1 cycle after mem_rd
//   busy          out  1        check in progress
//   pass          out  1        level: last check finished with 0 mismatches
//   fail          out  1        level: last check finished with >=1 mismatch
//   mismatch_cnt  out  32       mismatching elements in last/current check
//   first_bad_i   out  16       row of first mismatch (valid when fail)
//   first_bad_j   out  16       col of first mismatch (valid when fail)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; all outputs 0; i, j, k and acc = 0.
//   FSM: IDLE, REQ_A, REQ_B, MAC, REQ_R, CMP, DONE.
//   - IDLE/DONE + start: clear acc, i, j, k, mismatch_cnt, pass, fail, first_bad_*; go to REQ_A; busy=1.
//   - REQ_A: mem_rd=1, mem_addr=BASE_A+i*N+k, then REQ_B.
//   - REQ_B: latch a=mem_rdata; mem_rd=1, mem_addr=BASE_B+k*N2+j, then MAC.
//   - MAC: acc <= acc + a*mem_rdata. Product and sum are truncated to WIDTH (mod 2^WIDTH).
//       If k==N-1: k=0, go to REQ_R. Otherwise k++, go to REQ_A.
//   - REQ_R: mem_rd=1, mem_addr=BASE_R+i*N2+j, then CMP.
//   - CMP: if mem_rdata!=acc, mismatch_cnt++. If this is the first mismatch, latch first_bad_i=i and
//       first_bad_j=j. Clear acc. Advance j; when j wraps at N2, j=0 and i++.
//       If (i,j)==(M-1,N2-1), go to DONE. Otherwise go to REQ_A.
//   - DONE: busy=0; pass=(mismatch_cnt==0), fail=!pass. Both hold until the next start or reset.
//   mem_rd=0 in every state not listed above; mem_addr is don't-care when mem_rd=0.
//   Latency: exactly M*N2*(3N+2)+1 cycles from the start edge to busy falling.
//   start while busy: ignored; no restart, no counter disturbance.
//   start in the same cycle as the final CMP: ignored, because busy is still 1.
//   Reset mid-check: returns to IDLE at once; pass and fail are both 0 (no stale verdict).
//   mismatch_cnt saturates at 32'hFFFF_FFFF. Addresses wrap modulo 2^ADDR_W.
// CONFIGURATION
//   CHECKER_ABORT_ON_FIRST_EN defined: the first mismatch in CMP goes to DONE immediately.
//     Result: mismatch_cnt=1, fail=1, remaining elements are not read.
//   Not defined: every element is checked and all mismatches are counted (default).
// TESTING
//   1 M=N=N2=2, A=[1 2;3 4], B=[5 6;7 8], R=[19 22;43 50], start
//       -> pass=1, fail=0, mismatch_cnt=0, busy high for exactly 33 cycles.
//   2 Same setup with R[1][0]=44 -> fail=1, mismatch_cnt=1, first_bad_i=1, first_bad_j=0.
//   3 A=[-3 2;1 -1], B=[4 -5;2 7], R=[-8 29;2 -12] -> pass=1 (signed arithmetic).
//   4 WIDTH=8, A row=[127 127], B col=[2 2], R=8'hFC -> pass=1 (mod-2^WIDTH wrap).
//   5 Pulse start every cycle during a run -> one run only; latency unchanged.
//     Pulse rst_n low mid-run -> same cycle: busy=0, pass=0, fail=0, mismatch_cnt=0.
//   6 With CHECKER_ABORT_ON_FIRST_EN, corrupt R[0][1] and R[1][1]
//       -> mismatch_cnt=1, first_bad=(0,1), no mem_rd seen after that CMP.

Source files
------------

// File: rtl/matmul_result_checker_if.sv
// matmul_result_checker_if: spare memory read port between the result checker and data memory.
interface matmul_result_checker_if #(parameter int ADDR_W = 16, parameter int WIDTH = 32);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_rdata;
  modport master (output mem_rd, mem_addr, input mem_rdata);
  modport slave  (input mem_rd, mem_addr, output mem_rdata);
endinterface

// File: rtl/matmul_result_checker.sv
// matmul_result_checker: recomputes R = A x B from memory and compares with the stored result.
// Define CHECKER_ABORT_ON_FIRST_EN to stop at the first mismatching element.
module matmul_result_checker #(
  parameter int M      = 100,
  parameter int N      = 50,
  parameter int N2     = 2,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 16,
  parameter int BASE_A = 0,
  parameter int BASE_B = M*N,
  parameter int BASE_R = M*N + N*N2
) (
  input  logic                    CLOCK_50,
  input  logic                    rst_n,
  input  logic                    start,
  matmul_result_checker_if.master mem,
  output logic                    busy,
  output logic                    pass,
  output logic                    fail,
  output logic [31:0]             mismatch_cnt,
  output logic [15:0]             first_bad_i,
  output logic [15:0]             first_bad_j
);
  typedef enum logic [2:0] {IDLE, REQ_A, REQ_B, MAC, REQ_R, CMP, DONE} state_t;
  localparam logic [15:0] K_LAST = 16'(N - 1);
  localparam logic [15:0] J_LAST = 16'(N2 - 1);
  localparam logic [15:0] I_LAST = 16'(M - 1);
  state_t state, state_nx;
  logic [15:0] i, j, k;
  logic [WIDTH-1:0] a, acc;
  logic go, bad, j_wrap, last, abort;
  assign go     = start && !busy;
  assign bad    = mem.mem_rdata != acc;
  assign j_wrap = j == J_LAST;
  assign last   = j_wrap && i == I_LAST;
`ifdef CHECKER_ABORT_ON_FIRST_EN
  assign abort = bad;
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx     = state;
    mem.mem_rd   = 1'b0;
    mem.mem_addr = '0;
    case (state)
      IDLE, DONE: state_nx = go ? REQ_A : state;
      REQ_A: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = ADDR_W'(BASE_A + 32'(i) * N + 32'(k));
        state_nx     = REQ_B;
      end
      REQ_B: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = ADDR_W'(BASE_B + 32'(k) * N2 + 32'(j));
        state_nx     = MAC;
      end
      MAC: state_nx = k == K_LAST ? REQ_R : REQ_A;
      REQ_R: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = ADDR_W'(BASE_R + 32'(i) * N2 + 32'(j));
        state_nx     = CMP;
      end
      CMP: state_nx = last || abort ? DONE : REQ_A;
      default: state_nx = IDLE;
    endcase
  end
  // busy drops one cycle into DONE, which is when the verdict is published
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      {i, j, k, a, acc} <= '0;
      {busy, pass, fail} <= '0;
      mismatch_cnt <= '0;
      first_bad_i  <= '0;
      first_bad_j  <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (go) begin
            {i, j, k, acc} <= '0;
            {pass, fail} <= '0;
            busy         <= 1'b1;
            mismatch_cnt <= '0;
            first_bad_i  <= '0;
            first_bad_j  <= '0;
          end else if (busy) begin
            busy <= 1'b0;
            pass <= mismatch_cnt == 0;
            fail <= mismatch_cnt != 0;
          end
        REQ_B: a <= mem.mem_rdata;
        MAC: begin
          acc <= acc + a * mem.mem_rdata;
          k   <= k == K_LAST ? '0 : k + 16'd1;
        end
        CMP: begin
          if (bad) begin
            mismatch_cnt <= mismatch_cnt == '1 ? mismatch_cnt : mismatch_cnt + 32'd1;
            if (mismatch_cnt == 0) begin
              first_bad_i <= i;
              first_bad_j <= j;
            end
          end
          acc <= '0;
          j   <= j_wrap ? '0 : j + 16'd1;
          i   <= j_wrap ? i + 16'd1 : i;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_matmul_result_checker.sv
// tb_matmul_result_checker: directed and random matrix checks against a loop-level reference model.
module tb_matmul_result_checker;
  localparam int M = 2, N = 2, N2 = 2;
  localparam int BA = 0, BB = M*N, BR = M*N + N*N2;
  logic clk = 0, rst_n = 0, start = 0;
  logic busy, pass, fail;
  logic [31:0] mismatch_cnt;
  logic [15:0] first_bad_i, first_bad_j;
  logic [31:0] mem_arr [64];
  int vectors = 0, miscompares = 0, rd_total = 0;

  matmul_result_checker_if #(.ADDR_W(16), .WIDTH(32)) mif ();
  matmul_result_checker #(.M(M), .N(N), .N2(N2), .WIDTH(32), .ADDR_W(16)) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .start(start), .mem(mif.master), .busy(busy), .pass(pass),
    .fail(fail), .mismatch_cnt(mismatch_cnt), .first_bad_i(first_bad_i), .first_bad_j(first_bad_j));

  always #5 clk = ~clk;
  initial mif.mem_rdata = '0;
  always @(posedge clk)
    if (mif.mem_rd) begin
      mif.mem_rdata <= mem_arr[mif.mem_addr[5:0]];
      rd_total <= rd_total + 1;
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int a[4], input int b[4], input int r[4]);
    for (int x = 0; x < 4; x++) begin
      mem_arr[BA + x] = 32'(a[x]);
      mem_arr[BB + x] = 32'(b[x]);
      mem_arr[BR + x] = 32'(r[x]);
    end
  endtask

  function automatic logic [31:0] dot(input int i, input int j);
    logic [31:0] s = 0;
    for (int k = 0; k < N; k++) s += mem_arr[BA + i*N + k] * mem_arr[BB + k*N2 + j];
    return s;
  endfunction

  task automatic model(output int cnt, output int bi, output int bj, output int elems);
    bit stop = 0;
    cnt = 0; bi = 0; bj = 0; elems = 0;
    for (int e = 0; e < M*N2 && !stop; e++) begin
      elems++;
      if (dot(e / N2, e % N2) !== mem_arr[BR + e]) begin
        if (cnt == 0) begin bi = e / N2; bj = e % N2; end
        cnt++;
`ifdef CHECKER_ABORT_ON_FIRST_EN
        stop = 1;
`endif
      end
    end
  endtask

  task automatic run(input string tag, input bit spam);
    int ec, ei, ej, el, cyc, r0;
    model(ec, ei, ej, el);
    r0 = rd_total;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = spam;
    cyc = 0;
    while (busy && cyc < 2000) begin cyc++; @(posedge clk); #1; end
    start = 0;
    check({tag, ":latency"}, cyc, el*(3*N + 2) + 1);
    check({tag, ":pass"}, pass, ec == 0);
    check({tag, ":fail"}, fail, ec != 0);
    check({tag, ":cnt"}, mismatch_cnt, ec);
    check({tag, ":reads"}, rd_total - r0, el*(2*N + 1));
    if (ec != 0) begin
      check({tag, ":bad_i"}, first_bad_i, ei);
      check({tag, ":bad_j"}, first_bad_j, ej);
    end
  endtask

  initial begin
    foreach (mem_arr[x]) mem_arr[x] = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_cnt", mismatch_cnt, 0);
    rst_n = 1;
    load('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{19, 22, 43, 50});
    run("good", 0);
    check("good_lat33_pass", pass, 1);
    mem_arr[BR + 2] = 44;
    run("bad10", 0);
    load('{-3, 2, 1, -1}, '{4, -5, 2, 7}, '{-8, 29, 2, -12});
    run("signed", 0);
    load('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{19, 0, 43, 0});
    run("two_bad", 0);
    load('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{19, 22, 43, 50});
    run("start_spam", 1);
    mem_arr[BR + 1] = 7;
    run("pre_reset", 0);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_pass", pass, 0);
    check("midrst_fail", fail, 0);
    check("midrst_cnt", mismatch_cnt, 0);
    check("midrst_rd", mif.mem_rd, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int t = 0; t < 8; t++) begin
      for (int x = 0; x < 4; x++) begin
        mem_arr[BA + x] = $urandom;
        mem_arr[BB + x] = $urandom;
      end
      for (int e = 0; e < M*N2; e++) mem_arr[BR + e] = dot(e / N2, e % N2);
      repeat ($urandom_range(0, 3)) mem_arr[BR + $urandom_range(0, 3)] ^= 32'(1 << $urandom_range(0, 31));
      run($sformatf("rand%0d", t), t[0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
